// File: rtl/rom_download_writer.sv
// Packs loader download bytes into big-endian 16-bit words and writes them to
// the SDRAM controller's ROM port through a small word FIFO and a toggle handshake.
module rom_download_writer #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] PAD_BYTE   = 8'h00
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [23:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic        romwr_req,
  input  logic        romwr_ack,
  output logic [22:0] romwr_a,
  output logic [15:0] romwr_d,
  output logic [23:0] rom_size,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic        downl_q, downl_d;
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic [38:0] mem_q [FIFO_DEPTH];
  logic [38:0] mem_d [FIFO_DEPTH];
  logic        hold_valid_q, hold_valid_d;
  logic [7:0]  hold_byte_q, hold_byte_d;
  logic [22:0] hold_addr_q, hold_addr_d;
  logic        req_q, req_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] word_q, word_d;
  logic [23:0] size_q, size_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        wait_q, wait_d;

  logic [PW:0] count, free, wr_next1;
  logic        empty, start, strobe, ack_match, finish_ok;
  logic [22:0] waddr;
  logic [23:0] size_base, new_end;
  logic        push0, push1, acc0, acc1, drop;
  logic [38:0] push0_word, push1_word, head;
  logic        req_base;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign free      = (PW+1)'(FIFO_DEPTH) - count;
  assign empty     = (count == '0);
  assign start     = ioctl_downl & ~downl_q;
  assign strobe    = ioctl_wr & ioctl_downl;
  assign waddr     = ioctl_addr[23:1];
  assign ack_match = (romwr_ack == req_q);
  assign wr_next1  = wr_ptr_q + (PW+1)'(1);
  assign head      = mem_q[rd_ptr_q[PW-1:0]];
  assign new_end   = {waddr + 23'd1, 1'b0};

  // Byte packing, hold flush at download end, and FIFO write side (up to two words per strobe)
  always_comb begin
    push0       = 1'b0;
    push1       = 1'b0;
    push0_word  = '0;
    push1_word  = '0;
    hold_valid_d = hold_valid_q;
    hold_byte_d  = hold_byte_q;
    hold_addr_d  = hold_addr_q;
    size_base   = start ? 24'd0 : size_q;
    size_d      = size_base;

    if (strobe) begin
      if (new_end > size_base) size_d = new_end;
      if (!ioctl_addr[0]) begin
        if (hold_valid_q && (hold_addr_q != waddr)) begin
          push0      = 1'b1;
          push0_word = {hold_addr_q, hold_byte_q, PAD_BYTE};
        end
        hold_valid_d = 1'b1;
        hold_byte_d  = ioctl_data;
        hold_addr_d  = waddr;
      end else begin
        hold_valid_d = 1'b0;
        push0        = 1'b1;
        if (hold_valid_q && (hold_addr_q == waddr)) begin
          push0_word = {waddr, hold_byte_q, ioctl_data};
        end else if (hold_valid_q) begin
          push0_word = {hold_addr_q, hold_byte_q, PAD_BYTE};
          push1      = 1'b1;
          push1_word = {waddr, PAD_BYTE, ioctl_data};
        end else begin
          push0_word = {waddr, PAD_BYTE, ioctl_data};
        end
      end
    end else if (!ioctl_downl && hold_valid_q && (free != '0)) begin
      push0        = 1'b1;
      push0_word   = {hold_addr_q, hold_byte_q, PAD_BYTE};
      hold_valid_d = 1'b0;
    end

    acc0 = push0 && (free >= (PW+1)'(1));
    acc1 = push1 && (free >= (PW+1)'(2));
    drop = (push0 && !acc0) || (push1 && !acc1);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (acc0) begin
      mem_d[wr_ptr_q[PW-1:0]] = push0_word;
      wr_ptr_d = wr_next1;
    end
    if (acc1) begin
      mem_d[wr_next1[PW-1:0]] = push1_word;
      wr_ptr_d = wr_ptr_q + (PW+1)'(2);
    end

    ovf_d = start ? 1'b0 : ovf_q;
    if (drop) ovf_d = 1'b1;
  end

  // Write FSM: a download start resyncs req to ack before any toggle this cycle
  always_comb begin
    state_d  = state_q;
    req_base = start ? romwr_ack : req_q;
    req_d    = req_base;
    addr_d   = addr_q;
    word_d   = word_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          addr_d   = head[38:16];
          word_d   = head[15:0];
          req_d    = ~req_base;
          rd_ptr_d = rd_ptr_q + (PW+1)'(1);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ack_match) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Completion fires as soon as the last ack matches, so done lands one cycle later
  always_comb begin
    downl_d   = ioctl_downl;
    wait_d    = (count >= (PW+1)'(FIFO_DEPTH - 2));
    finish_ok = busy_q && !start && !ioctl_downl && !hold_valid_q && empty &&
                ((state_q == ST_IDLE) || ack_match);
    done_d    = finish_ok;
    busy_d    = busy_q;
    if (start) busy_d = 1'b1;
    else if (finish_ok) busy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q      <= ST_IDLE;
      downl_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      hold_valid_q <= 1'b0;
      hold_byte_q  <= '0;
      hold_addr_q  <= '0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      word_q       <= '0;
      size_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      wait_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      downl_q      <= downl_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
      hold_valid_q <= hold_valid_d;
      hold_byte_q  <= hold_byte_d;
      hold_addr_q  <= hold_addr_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      word_q       <= word_d;
      size_q       <= size_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      wait_q       <= wait_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign romwr_req  = req_q;
  assign romwr_a    = addr_q;
  assign romwr_d    = word_q;
  assign rom_size   = size_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;

endmodule
